// File: rtl/uart_pkg.sv
// Shared definitions for the debug-link UART: line levels, frame geometry and
// the transmitter state encoding.
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam int   UART_BIT_CNT_W   = $clog2(UART_DATA_BITS);
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // Line level driven while the transmitter sits in a given state.
    function automatic logic line_level(input uart_state_e st, input logic data_bit);
        logic lvl;
        case (st)
            START:   lvl = UART_START_LEVEL;
            DATA:    lvl = data_bit;
            STOP:    lvl = UART_STOP_LEVEL;
            default: lvl = UART_IDLE_LEVEL;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with an explicit occupancy counter, so full and
// empty come straight from a register rather than from pointer comparison.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == LEVEL_FULL);
    assign empty   = (level == '0);
    // Full blocks a push even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset && do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 LSB-first byte-stream transmitter: a valid/ready fed FIFO drains into
// back-to-back frames at a fixed clocks-per-bit divider.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DIVIDER_TICKS_WIDTH = 10,
    parameter int DIVIDER_TICKS       = 1023,
    parameter int FIFO_DEPTH_LOG2     = 4
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic [7:0]                 data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic                       tx_out,
    output logic                       busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam logic [DIVIDER_TICKS_WIDTH-1:0] DIV_LAST =
        DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
    localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST =
        UART_BIT_CNT_W'(UART_DATA_BITS - 1);

    uart_state_e                     state_q;
    uart_state_e                     state_nxt;
    logic [DIVIDER_TICKS_WIDTH-1:0]  div_q;
    logic [UART_BIT_CNT_W-1:0]       bit_cnt_q;
    logic [UART_DATA_BITS-1:0]       shift_q;
    logic                            tx_q;
    logic                            div_wrap;
    logic                            pop;
    logic                            push;
    logic [7:0]                      fifo_rdata;
    logic                            fifo_full;
    logic                            fifo_empty;

    assign data_ready = !fifo_full;
    assign push       = data_valid && data_ready;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign tx_out     = tx_q;
    assign div_wrap   = (div_q == DIV_LAST);

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_in (clk_in),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wdata  (data_in),
        .rdata  (fifo_rdata),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (div_wrap) state_nxt = DATA;
            end
            DATA: begin
                if (div_wrap && bit_cnt_q == BIT_LAST) state_nxt = STOP;
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (div_wrap) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_nxt;

            if (pop)
                div_q <= '0;
            else if (state_q != IDLE)
                div_q <= div_wrap ? '0 : div_q + 1'b1;

            if (pop) begin
                shift_q   <= fifo_rdata;
                bit_cnt_q <= '0;
            end else if (state_q == DATA && div_wrap) begin
                shift_q   <= shift_q >> 1;
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end

            // Line lags the state by one clock; every level still lasts DIVIDER_TICKS.
            tx_q <= line_level(state_q, shift_q[0]);
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboarded bench: accepted bytes are queued by an acceptance tracker and a
// line monitor decodes each frame and compares it to the ideal 8N1 waveform.
module tb_uart_tx_stream;

    localparam int D     = 4;
    localparam int DL2   = 2;
    localparam int FRAME = 10 * D;

    logic           tb_clk_baudrate = 1'b0;
    logic           reset;
    logic [7:0]     data_in;
    logic           data_valid;
    logic           data_ready;
    logic           tx_out;
    logic           busy;
    logic [DL2:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    uart_tx_stream #(
        .DIVIDER_TICKS_WIDTH (4),
        .DIVIDER_TICKS       (D),
        .FIFO_DEPTH_LOG2     (DL2)
    ) dut (
        .clk_in     (tb_clk_baudrate),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 tb_clk_baudrate = ~tb_clk_baudrate;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ideal line samples for one frame: start, 8 data bits LSB first, stop.
    function automatic logic [FRAME-1:0] ideal_wave(input logic [7:0] b);
        logic [FRAME-1:0] w;
        logic             lvl;
        w = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      lvl = 1'b0;
            else if (k == 9) lvl = 1'b1;
            else             lvl = b[k-1];
            for (int j = 0; j < D; j++) w[k*D + j] = lvl;
        end
        return w;
    endfunction

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         acc_q[$];
    int         cyc = 0;
    bit         last_acc = 0;
    int         accepted = 0;

    always @(posedge tb_clk_baudrate) begin
        cyc++;
        last_acc = 0;
        if (!reset && data_valid && data_ready) begin
            exp_q.push_back(data_in);
            acc_q.push_back(cyc);
            last_acc = 1;
            accepted++;
        end
    end

    bit               in_frame = 0;
    int               idx = 0;
    logic [FRAME-1:0] wave;
    logic [7:0]       cur;
    logic [7:0]       rx;
    int               frames_started = 0;
    int               frames_done = 0;

    always @(negedge tb_clk_baudrate) begin
        if (reset) begin
            in_frame = 0;
            exp_q.delete();
        end else if (!in_frame) begin
            if (tx_out === 1'b0) begin
                in_frame = 1;
                wave = '0;
                wave[0] = tx_out;
                idx = 1;
                start_q.push_back(cyc);
                frames_started++;
                chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                cur = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            end
        end else begin
            wave[idx] = tx_out;
            idx++;
            if (idx == FRAME) begin
                in_frame = 0;
                frames_done++;
                for (int i = 0; i < 8; i++) rx[i] = wave[(1 + i) * D + D / 2];
                chk("frame_wave", 64'(wave), 64'(ideal_wave(cur)));
                chk("rx_byte", 64'(rx), 64'(cur));
                chk("stop_bit", 64'(wave[9 * D + D / 2]), 64'd1);
            end
        end
    end

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy !== 1'b0 || in_frame) && n < max_cyc) begin
            @(negedge tb_clk_baudrate);
            n++;
        end
        chk("idle_reached", 64'(n < max_cyc), 64'd1);
        repeat (3) @(negedge tb_clk_baudrate);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;
        int base_acc;
        int base_done;
        int n;
        int win;
        int lows;
        bit full_seen;

        reset = 1'b1;
        data_valid = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge tb_clk_baudrate);
        #1 reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_clk_baudrate);
            chk("reset_idle", 64'({tx_out, busy, data_ready, fifo_level}),
                64'({1'b1, 1'b0, 1'b1, 3'd0}));
        end

        // Single byte 0x4C: latency and busy fall
        #1 data_in = 8'h4C; data_valid = 1'b1;
        @(negedge tb_clk_baudrate);
        #1 data_valid = 1'b0;
        chk("single_level1", 64'(fifo_level), 64'd1);
        chk("single_busy", 64'(busy), 64'd1);
        @(negedge tb_clk_baudrate);
        chk("single_popped", 64'({fifo_level, tx_out}), 64'({3'd0, 1'b1}));
        @(negedge tb_clk_baudrate);
        chk("single_start_low", 64'(tx_out), 64'd0);
        for (int i = 3; i <= 40; i++) @(negedge tb_clk_baudrate);
        chk("busy_last_stop", 64'(busy), 64'd1);
        @(negedge tb_clk_baudrate);
        chk("busy_fall", 64'(busy), 64'd0);
        wait_idle(200);

        // Three consecutive pushes: contiguous frames
        start_q.delete();
        #1 data_in = 8'h55; data_valid = 1'b1;
        @(negedge tb_clk_baudrate);
        #1 data_in = 8'hAA;
        @(negedge tb_clk_baudrate);
        #1 data_in = 8'h00;
        @(negedge tb_clk_baudrate);
        #1 data_valid = 1'b0;
        wait_idle(400);
        chk("b2b_frames", 64'(start_q.size()), 64'd3);
        if (start_q.size() == 3) begin
            diff = start_q[1] - start_q[0];
            chk("b2b_gap01", 64'(diff), 64'(FRAME));
            diff = start_q[2] - start_q[1];
            chk("b2b_gap12", 64'(diff), 64'(FRAME));
        end

        // Continuous valid with incrementing byte
        start_q.delete();
        acc_q.delete();
        base_acc = accepted;
        base_done = frames_done;
        full_seen = 0;
        n = 0;
        #1 data_in = 8'($urandom); data_valid = 1'b1;
        while (frames_done - base_done < 10 && n < 1000) begin
            @(negedge tb_clk_baudrate);
            if (fifo_level == 3'd4 && !data_ready) full_seen = 1;
            #1 if (last_acc) data_in = data_in + 8'd1;
            n++;
        end
        data_valid = 1'b0;
        chk("stream_frames_bound", 64'(n < 1000), 64'd1);
        chk("stream_full_seen", 64'(full_seen), 64'd1);
        for (int f = 4; f < 6; f++) begin
            if (start_q.size() > f + 1) begin
                win = 0;
                foreach (acc_q[i])
                    if (acc_q[i] >= start_q[f] && acc_q[i] < start_q[f + 1]) win++;
                chk("one_accept_per_frame", 64'(win), 64'd1);
            end
        end
        wait_idle(600);
        chk("stream_no_loss", 64'(frames_done - base_done), 64'(accepted - base_acc));
        chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);

        // Randomised bytes with random valid gaps
        base_acc = accepted;
        base_done = frames_done;
        n = 0;
        #1 data_valid = 1'b0;
        while (accepted - base_acc < 30 && n < 3000) begin
            @(negedge tb_clk_baudrate);
            #1 if (last_acc || !data_valid) begin
                data_valid = ($urandom_range(0, 2) != 0);
                data_in = 8'($urandom);
            end
            n++;
        end
        data_valid = 1'b0;
        chk("rand_bound", 64'(n < 3000), 64'd1);
        wait_idle(2000);
        chk("rand_no_loss", 64'(frames_done - base_done), 64'(accepted - base_acc));

        // Reset during the data bits with two bytes queued
        #1 data_in = 8'($urandom); data_valid = 1'b1;
        @(negedge tb_clk_baudrate);
        #1 data_in = 8'($urandom);
        @(negedge tb_clk_baudrate);
        #1 data_in = 8'($urandom);
        @(negedge tb_clk_baudrate);
        #1 data_valid = 1'b0;
        repeat (10) @(negedge tb_clk_baudrate);
        chk("pre_reset_level", 64'(fifo_level), 64'd2);
        #1 reset = 1'b1;
        @(negedge tb_clk_baudrate);
        chk("rst_tx_high", 64'(tx_out), 64'd1);
        chk("rst_level0", 64'(fifo_level), 64'd0);
        chk("rst_busy0", 64'(busy), 64'd0);
        chk("rst_ready1", 64'(data_ready), 64'd1);
        #1 reset = 1'b0;
        base_done = frames_started;
        lows = 0;
        repeat (100) begin
            @(negedge tb_clk_baudrate);
            if (tx_out !== 1'b1) lows++;
        end
        chk("rst_line_quiet", 64'(lows), 64'd0);
        chk("rst_no_frames", 64'(frames_started - base_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
